// File: rtl/rr_encoder_4_2_pkg.sv
// Shared constants and helpers for the round-robin request encoder.
// Latency: none (package only).
// Backpressure: not applicable.
//
// Holds the FSM state encodings, requester count and the 2->4 one-hot
// decode used to form the per-requester acknowledge.
package rr_encoder_4_2_pkg;

    localparam int RR_IDX_W = 2;
    localparam int RR_N     = 1 << RR_IDX_W;

    // 1-bit state register encodings
    localparam logic RR_IDLE  = 1'b0;
    localparam logic RR_GRANT = 1'b1;

    // 2->4 one-hot decode
    function automatic logic [3:0] decoder_2_4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_encoder_4_2_pri_encoder.sv
// Fixed-priority 4->2 encoder: lowest set bit wins.
// Latency: combinational.
// Backpressure: not applicable.
//
// Ports:
//   in   [3:0]  request vector
//   idx  [1:0]  index of lowest set bit (0 when in == 0)
//   any         at least one bit of in is set
module pri_encoder_4_2 (
    input  logic [3:0] in,
    output logic [1:0] idx,
    output logic       any
);

    always_comb begin
        idx = 2'd0;
        any = |in;
        if (in[0])      idx = 2'd0;
        else if (in[1]) idx = 2'd1;
        else if (in[2]) idx = 2'd2;
        else if (in[3]) idx = 2'd3;
    end

endmodule

// File: rtl/rr_encoder_4_2.sv
// Round-robin 4-requester encoder: registered grant index, valid/ready handshake, one-hot ack.
// Latency: req in IDLE -> grant_valid next cycle; handshake -> req_ack next cycle.
// Backpressure: grant_idx/grant_valid held stable while grant_ready is low; grant never withdrawn.
//
// Ports:
//   clk          clock, all state on posedge
//   rst          synchronous active-high reset
//   req   [3:0]  level requests, held until the matching req_ack
//   grant_idx    granted requester index (meaningful with grant_valid)
//   grant_valid  grant offered downstream
//   grant_ready  downstream accepts the grant
//   req_ack[3:0] one-cycle one-hot pulse to the accepted requester
//   busy         high while a grant is outstanding
module rr_encoder_4_2
    import rr_encoder_4_2_pkg::*;
#(
    parameter int               IDX_W   = RR_IDX_W,
    parameter logic [IDX_W-1:0] RST_PTR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [(1<<IDX_W)-1:0]  req,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_valid,
    input  logic                   grant_ready,
    output logic [(1<<IDX_W)-1:0]  req_ack,
    output logic                   busy
);

    logic             state;
    logic [1:0]       ptr;
    logic             ack_en;
    logic [3:0]       eff;
    logic [3:0]       rot;
    logic [1:0]       enc_idx;
    logic             enc_any;
    logic [1:0]       pick;

    // grant_idx is not reloaded on the handshake edge, so during the ack
    // cycle it still names the requester just served.
    assign req_ack = ack_en ? decoder_2_4(grant_idx) : 4'b0000;
    assign busy    = (state == RR_GRANT);

    // A requester that is being acked this cycle may not have dropped req
    // yet; masking it prevents an immediate second grant.
    assign eff = req & ~req_ack;

    // Rotate right by ptr so the highest-priority requester lands on bit 0.
    always_comb begin
        rot = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            rot[j] = eff[ptr + 2'(j)];
        end
    end

    pri_encoder_4_2 u_pri (
        .in  (rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    // Undo the rotation (2-bit add wraps mod 4).
    assign pick = enc_idx + ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RR_IDLE;
            ptr         <= RST_PTR;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            ack_en      <= 1'b0;
        end else begin
            ack_en <= 1'b0;
            case (state)
                RR_IDLE: begin
                    if (enc_any) begin
                        grant_idx   <= pick;
                        grant_valid <= 1'b1;
                        state       <= RR_GRANT;
                    end
                end
                RR_GRANT: begin
                    if (grant_valid && grant_ready) begin
                        ack_en      <= 1'b1;
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + 2'd1;
                        state       <= RR_IDLE;
                    end
                end
                default: begin
                    state       <= RR_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_encoder_4_2.sv
// Self-checking bench for rr_encoder_4_2: directed scenarios then random traffic.
// Latency: n/a.
// Backpressure: grant_ready driven directly, including long low stretches.
module tb_rr_encoder_4_2;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       grant_ready;
    logic [3:0] req_ack;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // Reference model: outstanding grant, its requester, rotation start, ack vector
    bit       m_pending = 1'b0;
    int       m_idx     = 0;
    int       m_ptr     = 0;
    bit [3:0] m_ack     = 4'b0000;

    rr_encoder_4_2 dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .req_ack     (req_ack),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // First eligible requester scanning from p upward, wrapping; -1 if none.
    function automatic int rr_pick(input bit [3:0] eligible, input int p);
        for (int k = 0; k < 4; k++) begin
            if (eligible[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_edge();
        bit [3:0] prev_ack;
        int       w;
        prev_ack = m_ack;
        m_ack    = 4'b0000;
        if (rst) begin
            m_pending = 1'b0;
            m_ptr     = 0;
            m_idx     = 0;
        end else if (!m_pending) begin
            w = rr_pick(req & ~prev_ack, m_ptr);
            if (w >= 0) begin
                m_idx     = w;
                m_pending = 1'b1;
            end
        end else if (grant_ready) begin
            m_ack     = 4'b0001 << m_idx;
            m_pending = 1'b0;
            m_ptr     = (m_idx + 1) % 4;
        end
    endtask

    // One clock: update model at the edge, compare DUT 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".valid"}, {3'b0, grant_valid}, {3'b0, m_pending});
        chk({tag, ".busy"},  {3'b0, busy},        {3'b0, m_pending});
        chk({tag, ".ack"},   req_ack,             m_ack);
        if (m_pending) chk({tag, ".idx"}, {2'b0, grant_idx}, 4'(m_idx));
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        grant_ready = 1'b0;

        // 1: reset held with all requests asserted
        req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step("reset");
            chk("reset.valid0", {3'b0, grant_valid}, 4'd0);
            chk("reset.ack0",   req_ack,             4'b0000);
            chk("reset.busy0",  {3'b0, busy},        4'd0);
        end

        // 2: single requester 2, then ptr should sit at 3
        rst = 1'b0; req = 4'b0100; grant_ready = 1'b1;
        step("single.grant");
        chk("single.idx2", {2'b0, grant_idx}, 4'd2);
        step("single.ack");
        chk("single.ack0100", req_ack, 4'b0100);
        req = 4'b0000;
        step("single.idle");
        req = 4'b1111;
        step("single.ptr3");
        chk("single.next_idx3", {2'b0, grant_idx}, 4'd3);

        // 3: full rotation with every requester always asserting
        rst = 1'b1; step("rot.rst"); rst = 1'b0;
        req = 4'b1111; grant_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step("rot.grant");
            chk("rot.idx", {2'b0, grant_idx}, 4'(k % 4));
            step("rot.ack");
            chk("rot.ackvec", req_ack, 4'b0001 << (k % 4));
        end

        // 4: backpressure; request change during GRANT must be ignored
        rst = 1'b1; step("bp.rst"); rst = 1'b0;
        req = 4'b0010; grant_ready = 1'b0;
        step("bp.grant");
        for (int k = 0; k < 5; k++) begin
            if (k == 2) req = 4'b1000;
            step("bp.hold");
            chk("bp.idx1",   {2'b0, grant_idx},   4'd1);
            chk("bp.valid1", {3'b0, grant_valid}, 4'd1);
        end
        grant_ready = 1'b1;
        step("bp.release");
        chk("bp.ack0010", req_ack, 4'b0010);

        // 5: wrap from requester 3 back to 0, then on to 3
        rst = 1'b1; step("wrap.rst"); rst = 1'b0;
        req = 4'b1000; grant_ready = 1'b1;
        step("wrap.g3");
        step("wrap.a3");
        req = 4'b1001;
        step("wrap.g0");
        chk("wrap.idx0", {2'b0, grant_idx}, 4'd0);
        step("wrap.a0");
        step("wrap.g3b");
        chk("wrap.idx3", {2'b0, grant_idx}, 4'd3);

        // 6: reset while a grant is outstanding
        rst = 1'b1; step("mid.rst0"); rst = 1'b0;
        req = 4'b0100; grant_ready = 1'b0;
        step("mid.grant");
        chk("mid.idx2", {2'b0, grant_idx}, 4'd2);
        rst = 1'b1; grant_ready = 1'b1;
        step("mid.rst");
        chk("mid.valid0", {3'b0, grant_valid}, 4'd0);
        chk("mid.ack0",   req_ack,             4'b0000);
        rst = 1'b0; req = 4'b1111;
        step("mid.regrant");
        chk("mid.idx0", {2'b0, grant_idx}, 4'd0);

        // Random traffic, including occasional resets and protocol violations
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 49) == 0);
            req         = 4'($urandom);
            grant_ready = ($urandom_range(0, 2) != 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
